// File: rtl/corr_search_sequencer_pkg.sv
// Shared types, widths and default search geometry for the correlation search sequencer.
// Also holds the clipped-window helpers used when the fine pass is set up.
package corr_search_sequencer_pkg;

    localparam int COORD_W = 13;
    localparam int ARITH_W = 14;
    localparam int CORR_W  = 32;

    localparam int H_MAX_DEF  = 639;
    localparam int V_MAX_DEF  = 479;
    localparam int STEP_DEF   = 8;
    localparam int RADIUS_DEF = 7;

    typedef enum logic [2:0] {
        IDLE,
        C_ISSUE,
        C_WAIT,
        F_SETUP,
        F_ISSUE,
        F_WAIT,
        DONE
    } state_t;

    // Lower window edge: c - r, floored at 0 instead of wrapping.
    function automatic logic [COORD_W-1:0] win_lo(input logic [COORD_W-1:0] c,
                                                   input logic [ARITH_W-1:0] r);
        logic [ARITH_W-1:0] c_w;
        c_w = {1'b0, c};
        return (c_w >= r) ? COORD_W'(c_w - r) : '0;
    endfunction

    // Upper window edge: c + r, capped at lim; the extra bit keeps the sum exact.
    function automatic logic [COORD_W-1:0] win_hi(input logic [COORD_W-1:0] c,
                                                   input logic [ARITH_W-1:0] r,
                                                   input logic [ARITH_W-1:0] lim);
        logic [ARITH_W-1:0] s_w;
        s_w = {1'b0, c} + r;
        return (s_w > lim) ? COORD_W'(lim) : COORD_W'(s_w);
    endfunction

endpackage

// File: rtl/corr_search_sequencer_max_tracker.sv
// Running maximum of correlation results with the coordinate that produced it.
// Strictly-greater update, so on ties the earliest visited point is kept.
module corr_max_tracker
    import corr_search_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               upd_en,
    input  logic [COORD_W-1:0] cand_x,
    input  logic [COORD_W-1:0] cand_y,
    input  logic [CORR_W-1:0]  cand_val,
    output logic [COORD_W-1:0] best_x,
    output logic [COORD_W-1:0] best_y,
    output logic [CORR_W-1:0]  best_val
);

    logic [COORD_W-1:0] best_x_q, best_x_d;
    logic [COORD_W-1:0] best_y_q, best_y_d;
    logic [CORR_W-1:0]  best_val_q, best_val_d;

    always_comb begin
        best_x_d   = best_x_q;
        best_y_d   = best_y_q;
        best_val_d = best_val_q;
        if (clear) begin
            best_x_d   = '0;
            best_y_d   = '0;
            best_val_d = '0;
        end else if (upd_en && (cand_val > best_val_q)) begin
            best_x_d   = cand_x;
            best_y_d   = cand_y;
            best_val_d = cand_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_x_q   <= '0;
            best_y_q   <= '0;
            best_val_q <= '0;
        end else begin
            best_x_q   <= best_x_d;
            best_y_q   <= best_y_d;
            best_val_q <= best_val_d;
        end
    end

    assign best_x   = best_x_q;
    assign best_y   = best_y_q;
    assign best_val = best_val_q;

endmodule

// File: rtl/corr_search_sequencer.sv
// Two-pass correlation search: coarse grid over the frame, then a fine window
// around the coarse best. One engine job in flight at a time.
module corr_search_sequencer
    import corr_search_sequencer_pkg::*;
#(
    parameter int H_MAX  = H_MAX_DEF,
    parameter int V_MAX  = V_MAX_DEF,
    parameter int STEP   = STEP_DEF,
    parameter int RADIUS = RADIUS_DEF
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iFrameDone,
    input  logic               iAbort,
    output logic               oCorrStart,
    output logic [COORD_W-1:0] oX,
    output logic [COORD_W-1:0] oY,
    input  logic               iCorrDone,
    input  logic [CORR_W-1:0]  iCorrValue,
    output logic [COORD_W-1:0] oXresult,
    output logic [COORD_W-1:0] oYresult,
    output logic [CORR_W-1:0]  oBestCorr,
    output logic               oBusy,
    output logic               oFinished
);

    localparam logic [ARITH_W-1:0] H_LIM  = ARITH_W'(H_MAX);
    localparam logic [ARITH_W-1:0] V_LIM  = ARITH_W'(V_MAX);
    localparam logic [ARITH_W-1:0] STEP_W = ARITH_W'(STEP);
    localparam logic [ARITH_W-1:0] RAD_W  = ARITH_W'(RADIUS);

    state_t             state_q, state_d;
    logic               frame_q;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0] xlo_q, xlo_d, xhi_q, xhi_d, yhi_q, yhi_d;
    logic               start_q, start_d, busy_q, busy_d, fin_q, fin_d;
    logic               frame_rise, abort, trk_clear, trk_upd;
    logic [ARITH_W-1:0] x_step, y_step;
    logic [COORD_W-1:0] best_x, best_y;

    // frame_q resets high so a frame already valid at reset release is not an edge.
    assign frame_rise = iFrameDone & ~frame_q;
    assign abort      = busy_q & (iAbort | ~iFrameDone);
    assign x_step     = {1'b0, x_q} + STEP_W;
    assign y_step     = {1'b0, y_q} + STEP_W;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        xlo_d     = xlo_q;
        xhi_d     = xhi_q;
        yhi_d     = yhi_q;
        trk_clear = 1'b0;
        trk_upd   = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (frame_rise) begin
                        state_d   = C_ISSUE;
                        x_d       = '0;
                        y_d       = '0;
                        trk_clear = 1'b1;
                    end
                end
                C_ISSUE: state_d = C_WAIT;
                C_WAIT: begin
                    if (iCorrDone) begin
                        trk_upd = 1'b1;
                        state_d = C_ISSUE;
                        if (x_step > H_LIM) begin
                            x_d = '0;
                            if (y_step > V_LIM) state_d = F_SETUP;
                            else                y_d     = COORD_W'(y_step);
                        end else begin
                            x_d = COORD_W'(x_step);
                        end
                    end
                end
                F_SETUP: begin
                    xlo_d   = win_lo(best_x, RAD_W);
                    xhi_d   = win_hi(best_x, RAD_W, H_LIM);
                    yhi_d   = win_hi(best_y, RAD_W, V_LIM);
                    x_d     = win_lo(best_x, RAD_W);
                    y_d     = win_lo(best_y, RAD_W);
                    state_d = F_ISSUE;
                end
                F_ISSUE: state_d = F_WAIT;
                F_WAIT: begin
                    if (iCorrDone) begin
                        trk_upd = 1'b1;
                        state_d = F_ISSUE;
                        if (x_q == xhi_q) begin
                            x_d = xlo_q;
                            if (y_q == yhi_q) state_d = DONE;
                            else              y_d     = y_q + COORD_W'(1);
                        end else begin
                            x_d = x_q + COORD_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        start_d = (state_d == C_ISSUE) || (state_d == F_ISSUE);
        busy_d  = (state_d != IDLE) && (state_d != DONE);
        fin_d   = (state_d == DONE);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            frame_q <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
            xlo_q   <= '0;
            xhi_q   <= '0;
            yhi_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= iFrameDone;
            x_q     <= x_d;
            y_q     <= y_d;
            xlo_q   <= xlo_d;
            xhi_q   <= xhi_d;
            yhi_q   <= yhi_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
        end
    end

    corr_max_tracker u_tracker (
        .clk      (iCLK),
        .rst_n    (iRST_N),
        .clear    (trk_clear),
        .upd_en   (trk_upd),
        .cand_x   (x_q),
        .cand_y   (y_q),
        .cand_val (iCorrValue),
        .best_x   (best_x),
        .best_y   (best_y),
        .best_val (oBestCorr)
    );

    assign oCorrStart = start_q;
    assign oX         = x_q;
    assign oY         = y_q;
    assign oXresult   = best_x;
    assign oYresult   = best_y;
    assign oBusy      = busy_q;
    assign oFinished  = fin_q;

endmodule

// File: tb/tb_corr_search_sequencer.sv
// Bench for corr_search_sequencer: job-order scoreboard, engine responder with
// random latency, and directed abort/reset/frame-drop scenarios.
`timescale 1ns/1ps
module tb_corr_search_sequencer;

    localparam int H  = 31;
    localparam int V  = 15;
    localparam int ST = 8;
    localparam int R  = 2;

    logic        clk = 1'b0;
    logic        iRST_N, iFrameDone, iAbort, iCorrDone;
    logic [31:0] iCorrValue;
    logic        oCorrStart, oBusy, oFinished;
    logic [12:0] oX, oY, oXresult, oYresult;
    logic [31:0] oBestCorr;

    always #5 clk = ~clk;

    corr_search_sequencer #(.H_MAX(H), .V_MAX(V), .STEP(ST), .RADIUS(R)) dut (
        .iCLK(clk), .iRST_N(iRST_N), .iFrameDone(iFrameDone), .iAbort(iAbort),
        .oCorrStart(oCorrStart), .oX(oX), .oY(oY),
        .iCorrDone(iCorrDone), .iCorrValue(iCorrValue),
        .oXresult(oXresult), .oYresult(oYresult), .oBestCorr(oBestCorr),
        .oBusy(oBusy), .oFinished(oFinished)
    );

    typedef struct { int x; int y; } pt_t;
    pt_t exp_q[$];
    int  tests = 0, fails = 0;
    int  mode = 0, px = 13, py = 9;
    int  m_n, m_bv, m_bx, m_by, m_cbx, m_cby;
    int  starts_seen = 0, done_cnt = 0, abort_cnt = 0, abort_at = -1;
    int  outstanding = 0, jx = 0, jy = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int corr_val(input int x, input int y);
        if (mode == 1) return 5;
        return 10000 - (x - px) * (x - px) - (y - py) * (y - py);
    endfunction

    task automatic visit(input int x, input int y);
        pt_t p;
        p.x = x;
        p.y = y;
        exp_q.push_back(p);
        m_n++;
        if (corr_val(x, y) > m_bv) begin
            m_bv = corr_val(x, y);
            m_bx = x;
            m_by = y;
        end
    endtask

    // Whole search from the rules: coarse grid, then the clipped window around the coarse best.
    task automatic build_model();
        int xlo, xhi, ylo, yhi;
        exp_q.delete();
        m_n = 0; m_bv = 0; m_bx = 0; m_by = 0;
        for (int y = 0; y <= V; y += ST)
            for (int x = 0; x <= H; x += ST) visit(x, y);
        m_cbx = m_bx;
        m_cby = m_by;
        xlo = (m_cbx - R < 0) ? 0 : m_cbx - R;
        xhi = (m_cbx + R > H) ? H : m_cbx + R;
        ylo = (m_cby - R < 0) ? 0 : m_cby - R;
        yhi = (m_cby + R > V) ? V : m_cby + R;
        for (int y = ylo; y <= yhi; y++)
            for (int x = xlo; x <= xhi; x++) visit(x, y);
    endtask

    // Engine responder: accepts a start, answers after 1..50 cycles.
    initial begin : engine
        int e_pend, e_cnt, e_x, e_y;
        e_pend = 0; e_cnt = 0; e_x = 0; e_y = 0;
        iCorrDone = 1'b0; iAbort = 1'b0; iCorrValue = '0;
        forever begin
            @(negedge clk);
            iCorrDone = 1'b0;
            iAbort    = 1'b0;
            if (!iRST_N) begin
                e_pend = 0;
            end else begin
                if (e_pend != 0) begin
                    e_cnt--;
                    if (e_cnt == 0) begin
                        e_pend     = 0;
                        iCorrDone  = 1'b1;
                        iCorrValue = 32'(corr_val(e_x, e_y));
                        done_cnt++;
                        if (done_cnt == abort_at) begin
                            iAbort = 1'b1;
                            abort_cnt++;
                        end
                    end
                end
                if (oCorrStart) begin
                    e_pend = 1;
                    e_cnt  = int'($urandom_range(1, 50));
                    e_x    = int'(oX);
                    e_y    = int'(oY);
                end
            end
        end
    end

    // Per-cycle compare against the scoreboard and the one-job protocol.
    initial begin : chk_proc
        pt_t p;
        forever begin
            @(posedge clk);
            #1;
            if (!iRST_N) begin
                outstanding = 0;
            end else begin
                if (outstanding != 0) begin
                    if (iCorrDone) outstanding = 0;
                    else begin
                        check("job_x_stable", oX, jx);
                        check("job_y_stable", oY, jy);
                    end
                end
                if (oCorrStart) begin
                    check("one_job_outstanding", outstanding, 0);
                    if (exp_q.size() == 0) check("unexpected_start", oCorrStart, 0);
                    else begin
                        p = exp_q.pop_front();
                        check("job_x", oX, p.x);
                        check("job_y", oY, p.y);
                    end
                    outstanding = 1;
                    jx = int'(oX);
                    jy = int'(oY);
                    starts_seen++;
                end
                check("busy_with_finished", oBusy & oFinished, 0);
            end
        end
    end

    task automatic start_search();
        iFrameDone = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        iFrameDone = 1'b1;
        @(posedge clk);
        #2;
        check("start_busy", oBusy, 1);
        check("start_finished", oFinished, 0);
        check("start_best_cleared", oBestCorr, 0);
        check("start_xres_cleared", oXresult, 0);
        check("start_yres_cleared", oYresult, 0);
    endtask

    task automatic wait_starts(input int base, input int n);
        int t = 0;
        while ((starts_seen - base < n) && t < 4000) begin
            @(posedge clk);
            #2;
            t++;
        end
        check("starts_reached", starts_seen - base, n);
    endtask

    task automatic run_search(input string name, input int n, input int cbx, input int cby,
                              input int rx, input int ry, input int rv);
        int t = 0;
        build_model();
        check({name, "_model_jobs"}, m_n, n);
        check({name, "_model_coarse_x"}, m_cbx, cbx);
        check({name, "_model_coarse_y"}, m_cby, cby);
        check({name, "_model_best_x"}, m_bx, rx);
        check({name, "_model_best_y"}, m_by, ry);
        check({name, "_model_best_val"}, m_bv, rv);
        start_search();
        while (!oFinished && t < 6000) begin
            @(posedge clk);
            #2;
            t++;
        end
        check({name, "_finished"}, oFinished, 1);
        check({name, "_busy"}, oBusy, 0);
        check({name, "_jobs_left"}, exp_q.size(), 0);
        check({name, "_xresult"}, oXresult, m_bx);
        check({name, "_yresult"}, oYresult, m_by);
        check({name, "_bestcorr"}, oBestCorr, m_bv);
        iFrameDone = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check({name, "_hold_finished"}, oFinished, 1);
        check({name, "_hold_bestcorr"}, oBestCorr, m_bv);
        check({name, "_hold_xresult"}, oXresult, m_bx);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_start"}, oCorrStart, 0);
        check({name, "_x"}, oX, 0);
        check({name, "_y"}, oY, 0);
        check({name, "_xres"}, oXresult, 0);
        check({name, "_yres"}, oYresult, 0);
        check({name, "_best"}, oBestCorr, 0);
        check({name, "_busy"}, oBusy, 0);
        check({name, "_fin"}, oFinished, 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int base, t;
        iRST_N = 1'b0;
        iFrameDone = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        @(negedge clk);
        iRST_N = 1'b1;

        mode = 0; px = 13; py = 9;
        run_search("peak_13_9", 33, 16, 8, 14, 9, 9999);

        mode = 0; px = 0; py = 0;
        run_search("peak_0_0", 17, 0, 0, 0, 0, 10000);

        // Abort coincident with the third result: first two recorded only.
        mode = 0; px = 13; py = 9;
        build_model();
        abort_at = done_cnt + 3;
        base = abort_cnt;
        start_search();
        t = 0;
        while (abort_cnt == base && t < 4000) begin
            @(posedge clk);
            #2;
            t++;
        end
        check("abort_fired", abort_cnt - base, 1);
        check("abort_busy", oBusy, 0);
        check("abort_finished", oFinished, 0);
        check("abort_jobs_issued", 33 - exp_q.size(), 3);
        check("abort_bestcorr", oBestCorr, 9894);
        check("abort_xresult", oXresult, 8);
        check("abort_yresult", oYresult, 0);
        exp_q.delete();
        abort_at = -1;
        repeat (60) @(posedge clk);
        #2;
        check("abort_idle_busy", oBusy, 0);
        check("abort_idle_bestcorr", oBestCorr, 9894);

        // Frame drop while the fifth coarse job is in flight.
        build_model();
        base = starts_seen;
        start_search();
        wait_starts(base, 5);
        iFrameDone = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #2;
        check("drop_busy", oBusy, 0);
        check("drop_finished", oFinished, 0);
        repeat (60) @(posedge clk);
        #2;
        check("drop_bestcorr", oBestCorr, 9910);
        check("drop_xresult", oXresult, 16);
        check("drop_yresult", oYresult, 0);

        // Reset during the fine pass with the frame held valid.
        build_model();
        base = starts_seen;
        start_search();
        wait_starts(base, 10);
        @(posedge clk);
        #3;
        iRST_N = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        iRST_N = 1'b1;
        base = starts_seen;
        repeat (60) @(posedge clk);
        #2;
        check("no_start_after_reset", starts_seen - base, 0);
        check("post_reset_busy", oBusy, 0);
        check("post_reset_best", oBestCorr, 0);

        mode = 1;
        run_search("all_equal", 17, 0, 0, 0, 0, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/corr_search_sequencer.md
CORR_SEARCH_SEQUENCER -- requirements
Module: corr_search_sequencer

Interface
REQ-001 SHALL have parameter H_MAX, default 639, last valid X search coordinate.
REQ-002 SHALL have parameter V_MAX, default 479, last valid Y search coordinate.
REQ-003 SHALL have parameter STEP, default 8, coarse-pass grid pitch, power of two, 2..64.
REQ-004 SHALL have parameter RADIUS, default 7, fine-pass half-window around the coarse best.
REQ-005 SHALL have port iCLK, input, 1, the only clock.
REQ-006 SHALL have port iRST_N, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port iFrameDone, input, 1, level, high while a reference frame is stored and valid.
REQ-008 SHALL have port iAbort, input, 1, pulse, cancels the running search.
REQ-009 SHALL have port oCorrStart, output, 1, one-cycle start pulse to the correlation engine.
REQ-010 SHALL have ports oX, oY, output, 13 each, coordinate of the current engine job.
REQ-011 SHALL have port iCorrDone, input, 1, one-cycle pulse: engine finished the current job.
REQ-012 SHALL have port iCorrValue, input, 32, unsigned correlation result, valid with iCorrDone.
REQ-013 SHALL have ports oXresult, oYresult, output, 13 each, best coordinate found.
REQ-014 SHALL have port oBestCorr, output, 32, best correlation value found.
REQ-015 SHALL have ports oBusy and oFinished, output, 1 each, search in progress / result valid.

Function
REQ-016 SHALL implement states IDLE, C_ISSUE, C_WAIT, F_SETUP, F_ISSUE, F_WAIT, DONE.
REQ-017 IDLE -> C_ISSUE on a 0->1 edge of iFrameDone; clears best value to 0, best coordinate to (0,0), X=Y=0.
REQ-018 C_ISSUE: oCorrStart high for exactly one cycle, then C_WAIT; oX/oY stay stable from the start pulse until iCorrDone.
REQ-019 *_WAIT: on iCorrDone, if iCorrValue > best (strictly), best value and coordinate update in the same cycle; ties keep the earlier point.
REQ-020 Coarse scan SHALL be raster order: X steps by STEP up to the largest multiple of STEP <= H_MAX, then X=0 and Y += STEP, ending after the largest multiple of STEP <= V_MAX.
REQ-021 F_SETUP SHALL compute the window bounds as coarse best ±RADIUS, clipped to [0,H_MAX] and [0,V_MAX] with no wrap-around or underflow; it takes one cycle.
REQ-022 Fine scan SHALL visit every point in the clipped window in raster order by 1, including points already visited by the coarse pass.
REQ-023 After the last fine result: DONE, oFinished=1, oBusy=0; outputs hold until the next iFrameDone 0->1 edge, which restarts at REQ-017.
REQ-024 oBusy SHALL be 1 in every state except IDLE and DONE.
REQ-025 iCorrDone outside *_WAIT SHALL be ignored.
REQ-026 iAbort in any busy state SHALL go to IDLE within 1 cycle with oFinished=0, no further oCorrStart, and best registers left unchanged; iAbort in the same cycle as iCorrDone wins, and that result is discarded.
REQ-027 iFrameDone falling while busy SHALL behave as iAbort.
REQ-028 At most one job SHALL be outstanding: no oCorrStart before the previous iCorrDone.
REQ-029 Coordinate arithmetic SHALL use 14-bit intermediates so that X+STEP and best+RADIUS compare correctly at 13-bit maxima.

Reset
REQ-030 iRST_N low SHALL asynchronously force IDLE, all outputs to 0, and all best/counter registers to 0.
REQ-031 Reset deasserted with iFrameDone already high SHALL NOT start a search; a fresh 0->1 edge is required.

Structure
REQ-032 The state encoding and default H_MAX/V_MAX/STEP/RADIUS constants SHALL live in the shared SAVE parameter package.
REQ-033 One sub-module, corr_max_tracker (compare/update of best value and coordinate), SHALL be instantiated; everything else stays flat.

Verification
REQ-034 H_MAX=31, V_MAX=15, STEP=8, RADIUS=2, engine peak at (13,9) -> 8 coarse jobs, coarse best (16,8), fine window 14..18 x 6..10 (25 jobs), missed peak reported as best of fine set; model-checked result.
REQ-035 Peak at (0,0), RADIUS=2 -> fine window clipped to 0..2 x 0..2 (9 jobs), result (0,0), no wrapped coordinates.
REQ-036 All correlations equal 5 -> result (0,0), oBestCorr=5 (first-wins tie rule).
REQ-037 iAbort pulsed coincident with the 3rd iCorrDone -> IDLE next cycle, no further oCorrStart, oFinished=0, 3rd value not recorded.
REQ-038 iRST_N asserted mid-F_WAIT with iFrameDone held high -> all outputs 0 immediately; no oCorrStart until iFrameDone toggles 0->1.
REQ-039 Engine latency randomised 1..50 cycles -> oX/oY stable between each start and done pulse, and never two starts without a done between them.
